// File: rtl/mem_bus_ctrl.sv
// Byte-wide external memory bus controller: two address phases on a shared 8-bit pin bus,
// then a data phase with wait states and timeout. The last high address byte is cached so
// accesses within the same 256-byte page skip the high-address phase.
module mem_bus_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        write,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        done,
  output logic        err,
  output logic        busy,
  input  logic [7:0]  bus_in,
  output logic [7:0]  bus_out,
  output logic        bus_oe,
  output logic        mem_ale,
  output logic        mem_ahi,
  output logic        mem_re,
  output logic        mem_we,
  input  logic        mem_wait
);

  typedef enum logic [2:0] {StIdle, StAddrHi, StAddrLo, StData, StDone} state_e;

  // Last DATA cycle index; the abort fires when the counter sits here with wait still high.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  hi_q, hi_d;
  logic        hi_valid_q, hi_valid_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      write_q    <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 8'h00;
      rdata_q    <= 8'h00;
      hi_q       <= 8'h00;
      hi_valid_q <= 1'b0;
      cnt_q      <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      hi_q       <= hi_d;
      hi_valid_q <= hi_valid_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // Next-state, request capture, page cache and wait/timeout handling.
  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    hi_d       = hi_q;
    hi_valid_d = hi_valid_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          write_d = write;
          addr_d  = addr;
          wdata_d = wdata;
          err_d   = 1'b0;
          state_d = (hi_valid_q && (addr[15:8] == hi_q)) ? StAddrLo : StAddrHi;
        end
      end
      StAddrHi: begin
        hi_d       = addr_q[15:8];
        hi_valid_d = 1'b1;
        state_d    = StAddrLo;
      end
      StAddrLo: begin
        cnt_d   = 8'h00;
        state_d = StData;
      end
      StData: begin
        if (!mem_wait) begin
          if (!write_q) rdata_d = bus_in;
          state_d = StDone;
        end else if (cnt_q == TimeoutLast) begin
          // Abort: the page the device was left on is unknown, so drop the cache.
          err_d      = 1'b1;
          rdata_d    = 8'h00;
          hi_valid_d = 1'b0;
          state_d    = StDone;
        end else begin
          cnt_d = cnt_q + 8'h01;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Pin and core outputs decoded from registered state only.
  always_comb begin
    bus_out = 8'h00;
    bus_oe  = 1'b0;
    mem_ale = 1'b0;
    mem_ahi = 1'b0;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    busy    = (state_q != StIdle);
    rdata   = rdata_q;
    unique case (state_q)
      StAddrHi: begin
        bus_out = addr_q[15:8];
        bus_oe  = 1'b1;
        mem_ale = 1'b1;
        mem_ahi = 1'b1;
      end
      StAddrLo: begin
        bus_out = addr_q[7:0];
        bus_oe  = 1'b1;
        mem_ale = 1'b1;
      end
      StData: begin
        if (write_q) begin
          bus_out = wdata_q;
          bus_oe  = 1'b1;
          mem_we  = 1'b1;
        end else begin
          mem_re = 1'b1;
        end
      end
      StDone: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: scenario tasks with a read-data scoreboard.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset, req, write, mem_wait;
  logic [15:0] addr;
  logic [7:0]  wdata, bus_in;
  logic [7:0]  rdata, bus_out;
  logic        done, err, busy, bus_oe, mem_ale, mem_ahi, mem_re, mem_we;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } exp_t;
  exp_t sb[$];
  logic [7:0] model_rdata;

  // Per-cycle observations of the most recent transaction (index = cycle after request).
  logic [7:0] o_bus[0:47];
  logic       o_oe[0:47], o_ale[0:47], o_ahi[0:47], o_re[0:47], o_we[0:47];
  logic       o_done[0:47], o_busy[0:47];
  logic [7:0] o_rdata;
  logic       o_err;

  mem_bus_ctrl #(.TIMEOUT(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .write   (write),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .done    (done),
    .err     (err),
    .busy    (busy),
    .bus_in  (bus_in),
    .bus_out (bus_out),
    .bus_oe  (bus_oe),
    .mem_ale (mem_ale),
    .mem_ahi (mem_ahi),
    .mem_re  (mem_re),
    .mem_we  (mem_we),
    .mem_wait(mem_wait)
  );

  always #5 clk = ~clk;

  // Issues one request at the next negedge, holds wait for 'waits' DATA cycles (<0: forever)
  // and records pins until done. Inputs are changed at negedges, outputs read there too.
  task automatic run_txn(input logic wr, input logic [15:0] a, input logic [7:0] wd,
                         input int waits, input logic [7:0] din, output int ncyc);
    int dcyc = 0;
    ncyc = -1;
    @(negedge clk);
    req = 1'b1; write = wr; addr = a; wdata = wd; mem_wait = 1'b0; bus_in = 8'hEE;
    for (int c = 1; c < 48; c++) begin
      @(negedge clk);
      // Drop req and scramble the captured inputs; the DUT must ignore both.
      req = 1'b0; addr = ~a; wdata = ~wd; write = ~wr;
      o_bus[c] = bus_out; o_oe[c] = bus_oe; o_ale[c] = mem_ale; o_ahi[c] = mem_ahi;
      o_re[c] = mem_re; o_we[c] = mem_we; o_done[c] = done; o_busy[c] = busy;
      if (done) begin
        o_rdata = rdata; o_err = err; ncyc = c; mem_wait = 1'b0;
        break;
      end
      if (mem_re || mem_we) begin
        mem_wait = (waits < 0) || (dcyc < waits);
        bus_in   = mem_wait ? 8'hEE : din;
        dcyc++;
      end else begin
        mem_wait = 1'b1;  // must be ignored outside DATA
        bus_in   = 8'hEE;
      end
    end
    if (ncyc < 0) begin
      checks++; errors++;
      $display("FAIL txn_timeout: no done within 47 cycles for addr %h", a);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; write = 1'b0; addr = 16'h0; wdata = 8'h0;
    bus_in = 8'h0; mem_wait = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rdata, bus_out, done, err, busy, bus_oe, mem_ale, mem_ahi, mem_re, mem_we} !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs: got rdata=%h bus_out=%h flags=%b%b%b%b%b%b%b%b want all 0",
               rdata, bus_out, done, err, busy, bus_oe, mem_ale, mem_ahi, mem_re, mem_we);
    end
    reset = 1'b0;
    model_rdata = 8'h00;
  endtask

  task automatic test_read_miss();
    int n;
    exp_t e, x;
    model_rdata = 8'hA5;
    sb.push_back('{rdata: 8'hA5, err: 1'b0});
    run_txn(1'b0, 16'h1234, 8'h00, 0, 8'hA5, n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL rd_latency: got %0d want 4", n); end
    checks++;
    if ({o_bus[1], o_oe[1], o_ale[1], o_ahi[1]} !== {8'h12, 3'b111}) begin
      errors++; $display("FAIL rd_addr_hi: got bus=%h oe/ale/ahi=%b%b%b want 12 111",
                         o_bus[1], o_oe[1], o_ale[1], o_ahi[1]);
    end
    checks++;
    if ({o_bus[2], o_oe[2], o_ale[2], o_ahi[2]} !== {8'h34, 3'b110}) begin
      errors++; $display("FAIL rd_addr_lo: got bus=%h oe/ale/ahi=%b%b%b want 34 110",
                         o_bus[2], o_oe[2], o_ale[2], o_ahi[2]);
    end
    checks++;
    if ({o_re[3], o_we[3], o_oe[3]} !== 3'b100) begin
      errors++; $display("FAIL rd_data_strobes: got re/we/oe=%b%b%b want 100",
                         o_re[3], o_we[3], o_oe[3]);
    end
    e = sb.pop_front(); x = '{rdata: o_rdata, err: o_err};
    checks++;
    if (x !== e) begin
      errors++; $display("FAIL rd_result: got rdata=%h err=%b want %h %b",
                         o_rdata, o_err, e.rdata, e.err);
    end
  endtask

  task automatic test_write_hit();
    int n;
    exp_t e, x;
    sb.push_back('{rdata: model_rdata, err: 1'b0});
    run_txn(1'b1, 16'h1235, 8'h7F, 0, 8'h00, n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL wr_latency: got %0d want 3", n); end
    checks++;
    if ({o_bus[1], o_ale[1], o_ahi[1]} !== {8'h35, 2'b10}) begin
      errors++; $display("FAIL wr_addr_lo: got bus=%h ale/ahi=%b%b want 35 10",
                         o_bus[1], o_ale[1], o_ahi[1]);
    end
    checks++;
    if ({o_bus[2], o_we[2], o_oe[2], o_re[2]} !== {8'h7F, 3'b110}) begin
      errors++; $display("FAIL wr_data: got bus=%h we/oe/re=%b%b%b want 7f 110",
                         o_bus[2], o_we[2], o_oe[2], o_re[2]);
    end
    e = sb.pop_front(); x = '{rdata: o_rdata, err: o_err};
    checks++;
    if (x !== e) begin
      errors++; $display("FAIL wr_result: got rdata=%h err=%b want %h %b",
                         o_rdata, o_err, e.rdata, e.err);
    end
  endtask

  task automatic test_wait();
    int n, re_cnt;
    exp_t e, x;
    model_rdata = 8'h5C;
    sb.push_back('{rdata: 8'h5C, err: 1'b0});
    run_txn(1'b0, 16'h1300, 8'h00, 3, 8'h5C, n);
    checks++;
    if (n !== 7) begin errors++; $display("FAIL wait_latency: got %0d want 7", n); end
    checks++;
    if ({o_ahi[1], o_ale[1], o_bus[1]} !== {2'b11, 8'h13}) begin
      errors++; $display("FAIL wait_addr_hi: got ahi/ale=%b%b bus=%h want 11 13",
                         o_ahi[1], o_ale[1], o_bus[1]);
    end
    re_cnt = 0;
    for (int c = 1; c <= n && c < 48; c++) if (o_re[c]) re_cnt++;
    checks++;
    if (re_cnt !== 4) begin errors++; $display("FAIL wait_re_cycles: got %0d want 4", re_cnt); end
    e = sb.pop_front(); x = '{rdata: o_rdata, err: o_err};
    checks++;
    if (x !== e) begin
      errors++; $display("FAIL wait_result: got rdata=%h err=%b want %h %b",
                         o_rdata, o_err, e.rdata, e.err);
    end
  endtask

  task automatic test_timeout();
    int n, re_cnt;
    exp_t e, x;
    model_rdata = 8'h00;
    sb.push_back('{rdata: 8'h00, err: 1'b1});
    run_txn(1'b0, 16'h1300, 8'h00, -1, 8'h99, n);
    // Page 0x13 is cached: ADDR_LO at 1, four DATA cycles 2..5, DONE at 6.
    checks++;
    if (n !== 6) begin errors++; $display("FAIL to_latency: got %0d want 6", n); end
    re_cnt = 0;
    for (int c = 1; c <= n && c < 48; c++) if (o_re[c]) re_cnt++;
    checks++;
    if (re_cnt !== 4) begin errors++; $display("FAIL to_re_cycles: got %0d want 4", re_cnt); end
    e = sb.pop_front(); x = '{rdata: o_rdata, err: o_err};
    checks++;
    if (x !== e) begin
      errors++; $display("FAIL to_result: got rdata=%h err=%b want %h %b",
                         o_rdata, o_err, e.rdata, e.err);
    end
    model_rdata = 8'h11;
    sb.push_back('{rdata: 8'h11, err: 1'b0});
    run_txn(1'b0, 16'h1301, 8'h00, 0, 8'h11, n);
    checks++;
    if ({n, o_ahi[1]} !== {32'd4, 1'b1}) begin
      errors++; $display("FAIL to_recache: got latency=%0d ahi=%b want 4 1", n, o_ahi[1]);
    end
    e = sb.pop_front(); x = '{rdata: o_rdata, err: o_err};
    checks++;
    if (x !== e) begin
      errors++; $display("FAIL to_next_result: got rdata=%h err=%b want %h %b",
                         o_rdata, o_err, e.rdata, e.err);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    req = 1'b1; write = 1'b1; addr = 16'h1302; wdata = 8'hC3; mem_wait = 1'b0;
    @(negedge clk);  // cycle 1: ADDR_LO (page hit)
    req = 1'b0;
    @(negedge clk);  // cycle 2: DATA
    checks++;
    if ({mem_we, bus_oe, bus_out} !== {2'b11, 8'hC3}) begin
      errors++; $display("FAIL rst_pre_data: got we/oe=%b%b bus=%h want 11 c3",
                         mem_we, bus_oe, bus_out);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({done, err, busy, bus_oe, mem_ale, mem_re, mem_we, bus_out, rdata} !== 23'h0) begin
      errors++; $display("FAIL rst_abort: got done=%b busy=%b oe=%b we=%b bus=%h rdata=%h want 0",
                         done, busy, bus_oe, mem_we, bus_out, rdata);
    end
    reset = 1'b0;
    model_rdata = 8'h42;
    sb.push_back('{rdata: 8'h42, err: 1'b0});
    run_txn(1'b0, 16'h1302, 8'h00, 0, 8'h42, n);
    checks++;
    if ({n, o_ahi[1], o_ale[1]} !== {32'd4, 2'b11}) begin
      errors++; $display("FAIL rst_recache: got latency=%0d ahi=%b want 4 1", n, o_ahi[1]);
    end
    begin
      exp_t e, x;
      e = sb.pop_front(); x = '{rdata: o_rdata, err: o_err};
      checks++;
      if (x !== e) begin
        errors++; $display("FAIL rst_next_result: got rdata=%h err=%b want %h %b",
                           o_rdata, o_err, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_done, exp_busy;
    exp_t e, x;
    @(negedge clk);
    // Page 0x40 is a miss, so the first transaction has ADDR_HI; later ones hit.
    req = 1'b1; write = 1'b0; addr = 16'h4000; mem_wait = 1'b0;
    for (int c = 0; c <= 24; c++) begin
      if (c > 0) @(negedge clk);
      exp_done = (c == 4) || (c > 4 && ((c - 4) % 4) == 0);
      exp_busy = !((c == 0) || (c > 4 && ((c - 5) % 4) == 0));
      if (exp_done) sb.push_back('{rdata: 8'(c - 1 + 8'h40), err: 1'b0});
      checks++;
      if ({done, busy, err} !== {exp_done, exp_busy, 1'b0}) begin
        errors++; $display("FAIL b2b_cycle%0d: got done/busy/err=%b%b%b want %b%b0",
                           c, done, busy, err, exp_done, exp_busy);
      end
      if (done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b2b_unexpected_done: cycle %0d rdata=%h", c, rdata);
        end else begin
          e = sb.pop_front(); x = '{rdata: rdata, err: err};
          checks++;
          if (x !== e) begin
            errors++; $display("FAIL b2b_rdata_c%0d: got %h want %h", c, rdata, e.rdata);
          end
        end
      end
      bus_in = 8'(c + 8'h40);
    end
    req = 1'b0;
    sb.delete();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_write_hit();
    test_wait();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
